ahb_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the AHB-to-APB bridge slave port among NUM_MASTERS AHB masters.

---
 rtl/ahb_arb_pkg.sv | 40 ++++
 rtl/ahb_arb_mux.sv | 35 +++
 rtl/ahb_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared constants, FSM encoding and the cyclic first-one search for the AHB round-robin arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int unsigned MAX_MASTERS = 8;

  typedef enum logic [0:0] {
    ST_PARK,
    ST_OWN
  } arb_state_e;

  // First set bit of req strictly after 'last', wrapping modulo n. Returns 'last' when req is empty.
  function automatic logic [2:0] rr_next(input logic [MAX_MASTERS-1:0] req,
                                         input logic [2:0]             last,
                                         input int unsigned            n);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
      if (!found && (i <= n)) begin
        idx = 4'(last) + 4'(i);
        if (idx >= 4'(n)) begin
          idx = idx - 4'(n);
        end
        if (req[idx[2:0]]) begin
          pick  = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ahb_arb_mux.sv
// N:1 selector: address/control follow the address-phase owner, write data the data-phase owner.
module ahb_arb_mux #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic [W-1:0]    sel_a_i,
  input  logic [W-1:0]    sel_d_i,
  input  logic [2*N-1:0]  htrans_i,
  input  logic [32*N-1:0] haddr_i,
  input  logic [N-1:0]    hwrite_i,
  input  logic [32*N-1:0] hwdata_i,
  output logic [1:0]      htrans_o,
  output logic [31:0]     haddr_o,
  output logic            hwrite_o,
  output logic [31:0]     hwdata_o
);

  always_comb begin
    htrans_o = htrans_i[1:0];
    haddr_o  = haddr_i[31:0];
    hwrite_o = hwrite_i[0];
    hwdata_o = hwdata_i[31:0];
    for (int i = 0; i < int'(N); i++) begin
      if (sel_a_i == W'(i)) begin
        htrans_o = htrans_i[2*i +: 2];
        haddr_o  = haddr_i[32*i +: 32];
        hwrite_o = hwrite_i[i];
      end
      if (sel_d_i == W'(i)) begin
        hwdata_o = hwdata_i[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter sharing the AHB-to-APB bridge among NUM_MASTERS masters with a per-grant quantum.
// Optional lock support is enabled by defining ARB_HLOCK_EN.
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned QUANTUM        = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  localparam int unsigned W             = $clog2(NUM_MASTERS)
) (
  input  logic                      Hclk,
  input  logic                      Hresetn,
  input  logic [NUM_MASTERS-1:0]    m_busreq,
  input  logic [2*NUM_MASTERS-1:0]  m_htrans,
  input  logic [32*NUM_MASTERS-1:0] m_haddr,
  input  logic [NUM_MASTERS-1:0]    m_hwrite,
  input  logic [32*NUM_MASTERS-1:0] m_hwdata,
  input  logic [NUM_MASTERS-1:0]    m_hlock,
  input  logic                      Hreadyout,
  output logic [NUM_MASTERS-1:0]    hgrant,
  output logic [W-1:0]              hmaster,
  output logic [W-1:0]              hmaster_dp,
  output logic [1:0]                Htrans,
  output logic [31:0]               Haddr,
  output logic                      Hwrite,
  output logic [31:0]               Hwdata,
  output logic                      Hreadyin
);

  localparam int unsigned CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [W-1:0]  DefIdx     = W'(DEFAULT_MASTER);
  localparam logic [W-1:0]  LastRstIdx = W'((DEFAULT_MASTER + NUM_MASTERS - 1) % NUM_MASTERS);
  localparam logic [CW-1:0] CountMax   = CW'(QUANTUM - 1);

  arb_state_e          state_q, state_d;
  logic [W-1:0]        hmaster_q, hmaster_d;
  logic [W-1:0]        hmaster_dp_q, hmaster_dp_d;
  logic [W-1:0]        last_q, last_d;
  logic [CW-1:0]       count_q, count_d;

  logic [NUM_MASTERS-1:0] grant_vec;
  logic [NUM_MASTERS-1:0] others;
  logic [W-1:0]           pick_any;
  logic [W-1:0]           pick_other;
  logic [1:0]             htrans_mux;
  logic                   owner_req;
  logic                   accept_ns;
  logic                   count_full;
  logic                   rearb;

`ifdef ARB_HLOCK_EN
  logic lock_seen_q, lock_seen_d;
  logic owner_lock;
  assign owner_lock = (state_q == ST_OWN) && m_hlock[hmaster_q];
`else
  logic unused_hlock;
  assign unused_hlock = ^m_hlock;
`endif

  assign grant_vec  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << hmaster_q;
  assign others     = m_busreq & ~grant_vec;
  assign owner_req  = m_busreq[hmaster_q];
  assign pick_any   = W'(rr_next(8'(m_busreq), 3'(last_q), NUM_MASTERS));
  assign pick_other = W'(rr_next(8'(others), 3'(last_q), NUM_MASTERS));
  assign accept_ns  = (state_q == ST_OWN) && (htrans_mux == HTRANS_NONSEQ);
  assign count_full = (count_q == CountMax);

  always_comb begin
    state_d      = state_q;
    hmaster_d    = hmaster_q;
    hmaster_dp_d = hmaster_dp_q;
    last_d       = last_q;
    count_d      = count_q;
    rearb        = 1'b0;
`ifdef ARB_HLOCK_EN
    lock_seen_d  = lock_seen_q;
    if (!Hreadyout && owner_lock) begin
      lock_seen_d = 1'b1;
    end
`endif
    // Everything ownership-related is frozen while the bridge stalls.
    if (Hreadyout) begin
      hmaster_dp_d = hmaster_q;
      unique case (state_q)
        ST_PARK: begin
          if (|m_busreq) begin
            hmaster_d = pick_any;
            last_d    = pick_any;
            count_d   = '0;
            state_d   = ST_OWN;
          end
        end
        ST_OWN: begin
          if (accept_ns && !count_full) begin
            count_d = count_q + 1'b1;
          end
          rearb = !owner_req || (accept_ns && count_full && (|others));
`ifdef ARB_HLOCK_EN
          if (owner_lock) begin
            rearb   = 1'b0;
            count_d = count_q;
          end else if (lock_seen_q) begin
            rearb = 1'b1;
          end
          lock_seen_d = owner_lock;
`endif
          if (rearb) begin
            count_d = '0;
            if (|others) begin
              hmaster_d = pick_other;
              last_d    = pick_other;
            end else begin
              hmaster_d = DefIdx;
              state_d   = ST_PARK;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q      <= ST_PARK;
      hmaster_q    <= DefIdx;
      hmaster_dp_q <= DefIdx;
      last_q       <= LastRstIdx;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      hmaster_q    <= hmaster_d;
      hmaster_dp_q <= hmaster_dp_d;
      last_q       <= last_d;
      count_q      <= count_d;
    end
  end

`ifdef ARB_HLOCK_EN
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      lock_seen_q <= 1'b0;
    end else begin
      lock_seen_q <= lock_seen_d;
    end
  end
`endif

  ahb_arb_mux #(
    .N (NUM_MASTERS),
    .W (W)
  ) u_mux (
    .sel_a_i  (hmaster_q),
    .sel_d_i  (hmaster_dp_q),
    .htrans_i (m_htrans),
    .haddr_i  (m_haddr),
    .hwrite_i (m_hwrite),
    .hwdata_i (m_hwdata),
    .htrans_o (htrans_mux),
    .haddr_o  (Haddr),
    .hwrite_o (Hwrite),
    .hwdata_o (Hwdata)
  );

  assign hgrant     = grant_vec;
  assign hmaster    = hmaster_q;
  assign hmaster_dp = hmaster_dp_q;
  assign Htrans     = (state_q == ST_OWN) ? htrans_mux : HTRANS_IDLE;
  assign Hreadyin   = Hreadyout;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter (N=3, QUANTUM=4, DEFAULT_MASTER=0) with a scoreboard queue.
module tb_ahb_rr_arbiter;

  localparam int N = 3;

  logic          Hclk;
  logic          Hresetn;
  logic [N-1:0]  m_busreq;
  logic [2*N-1:0] m_htrans;
  logic [32*N-1:0] m_haddr;
  logic [N-1:0]  m_hwrite;
  logic [32*N-1:0] m_hwdata;
  logic [N-1:0]  m_hlock;
  logic          Hreadyout;
  logic [N-1:0]  hgrant;
  logic [1:0]    hmaster;
  logic [1:0]    hmaster_dp;
  logic [1:0]    Htrans;
  logic [31:0]   Haddr;
  logic          Hwrite;
  logic [31:0]   Hwdata;
  logic          Hreadyin;

  int errors = 0;
  int checks = 0;

  int          exp_owner_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_dp_q[$];

  ahb_rr_arbiter #(
    .NUM_MASTERS    (3),
    .QUANTUM        (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .Hclk       (Hclk),
    .Hresetn    (Hresetn),
    .m_busreq   (m_busreq),
    .m_htrans   (m_htrans),
    .m_haddr    (m_haddr),
    .m_hwrite   (m_hwrite),
    .m_hwdata   (m_hwdata),
    .m_hlock    (m_hlock),
    .Hreadyout  (Hreadyout),
    .hgrant     (hgrant),
    .hmaster    (hmaster),
    .hmaster_dp (hmaster_dp),
    .Htrans     (Htrans),
    .Haddr      (Haddr),
    .Hwrite     (Hwrite),
    .Hwdata     (Hwdata),
    .Hreadyin   (Hreadyin)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 * 32'(i + 1);
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  // Requesting masters present back-to-back NONSEQ writes with a fixed address/data each.
  task automatic set_masters(input logic [N-1:0] req);
    m_busreq = req;
    for (int i = 0; i < N; i++) begin
      m_htrans[2*i +: 2] = req[i] ? 2'b10 : 2'b00;
      m_haddr[32*i +: 32]  = addr_of(i);
      m_hwdata[32*i +: 32] = data_of(i);
      m_hwrite[i]          = 1'b1;
    end
  endtask

  task automatic do_reset();
    Hresetn   = 1'b0;
    Hreadyout = 1'b1;
    m_hlock   = '0;
    set_masters('0);
    exp_owner_q.delete();
    exp_data_q.delete();
    exp_dp_q.delete();
    repeat (2) @(posedge Hclk);
    #1;
    Hresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL reset_hgrant got=%b exp=001", hgrant); end
    checks++; if (Htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans got=%b exp=00", Htrans); end
    checks++; if (hmaster !== 2'd0) begin errors++; $display("FAIL reset_hmaster got=%0d exp=0", hmaster); end
    checks++; if (hmaster_dp !== 2'd0) begin errors++; $display("FAIL reset_hmaster_dp got=%0d exp=0", hmaster_dp); end
    checks++; if (Hreadyin !== 1'b1) begin errors++; $display("FAIL reset_hreadyin got=%b exp=1", Hreadyin); end
  endtask

  task automatic test_single_write();
    logic [31:0] exp_d;
    do_reset();
    m_busreq = 3'b010;
    m_htrans = 6'b00_10_00;
    m_haddr[63:32]  = 32'h8000_0001;
    m_hwrite        = 3'b010;
    m_hwdata[63:32] = 32'h0000_0080;
    exp_data_q.push_back(32'h0000_0080);
    tick();
    checks++; if (hgrant !== 3'b010) begin errors++; $display("FAIL single_hgrant got=%b exp=010", hgrant); end
    checks++; if (hmaster !== 2'd1) begin errors++; $display("FAIL single_hmaster got=%0d exp=1", hmaster); end
    checks++; if (Htrans !== 2'b10) begin errors++; $display("FAIL single_htrans got=%b exp=10", Htrans); end
    checks++; if (Haddr !== 32'h8000_0001) begin errors++; $display("FAIL single_haddr got=%h exp=80000001", Haddr); end
    checks++; if (Hwrite !== 1'b1) begin errors++; $display("FAIL single_hwrite got=%b exp=1", Hwrite); end
    m_busreq = 3'b000;
    tick();
    exp_d = exp_data_q.pop_front();
    checks++; if (Hwdata !== exp_d) begin errors++; $display("FAIL single_hwdata got=%h exp=%h", Hwdata, exp_d); end
    checks++; if (hmaster_dp !== 2'd1) begin errors++; $display("FAIL single_hmaster_dp got=%0d exp=1", hmaster_dp); end
    checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL single_park_hgrant got=%b exp=001", hgrant); end
    checks++; if (Htrans !== 2'b00) begin errors++; $display("FAIL single_park_htrans got=%b exp=00", Htrans); end
    m_htrans = '0;
  endtask

  task automatic test_round_robin();
    int o;
    int d;
    logic [31:0] exp_d;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) exp_owner_q.push_back(g % 3);
    end
    set_masters(3'b111);
    for (int c = 0; c < 17; c++) begin
      tick();
      if (exp_dp_q.size() > 0) begin
        d = exp_dp_q.pop_front();
        exp_d = exp_data_q.pop_front();
        checks++; if (hmaster_dp !== 2'(d)) begin errors++; $display("FAIL rr_hmaster_dp c=%0d got=%0d exp=%0d", c, hmaster_dp, d); end
        checks++; if (Hwdata !== exp_d) begin errors++; $display("FAIL rr_hwdata c=%0d got=%h exp=%h", c, Hwdata, exp_d); end
      end
      if (exp_owner_q.size() > 0) begin
        o = exp_owner_q.pop_front();
        checks++; if (hmaster !== 2'(o)) begin errors++; $display("FAIL rr_hmaster c=%0d got=%0d exp=%0d", c, hmaster, o); end
        checks++; if (hgrant !== 3'(1 << o)) begin errors++; $display("FAIL rr_hgrant c=%0d got=%b exp=%0d", c, hgrant, o); end
        checks++; if (Haddr !== addr_of(o)) begin errors++; $display("FAIL rr_haddr c=%0d got=%h exp=%h", c, Haddr, addr_of(o)); end
        exp_dp_q.push_back(o);
        exp_data_q.push_back(data_of(o));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_masters(3'b011);
    repeat (4) tick();
    checks++; if (hmaster !== 2'd0) begin errors++; $display("FAIL stall_pre_hmaster got=%0d exp=0", hmaster); end
    Hreadyout = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL stall_hgrant c=%0d got=%b exp=001", c, hgrant); end
      checks++; if (hmaster !== 2'd0) begin errors++; $display("FAIL stall_hmaster c=%0d got=%0d exp=0", c, hmaster); end
      checks++; if (hmaster_dp !== 2'd0) begin errors++; $display("FAIL stall_hmaster_dp c=%0d got=%0d exp=0", c, hmaster_dp); end
      checks++; if (Hreadyin !== 1'b0) begin errors++; $display("FAIL stall_hreadyin c=%0d got=%b exp=0", c, Hreadyin); end
    end
    Hreadyout = 1'b1;
    tick();
    checks++; if (hgrant !== 3'b010) begin errors++; $display("FAIL stall_handover_hgrant got=%b exp=010", hgrant); end
    checks++; if (hmaster_dp !== 2'd0) begin errors++; $display("FAIL stall_handover_dp got=%0d exp=0", hmaster_dp); end
    tick();
    checks++; if (hmaster_dp !== 2'd1) begin errors++; $display("FAIL stall_dp_follow got=%0d exp=1", hmaster_dp); end
    checks++; if (Hwdata !== data_of(1)) begin errors++; $display("FAIL stall_hwdata got=%h exp=%h", Hwdata, data_of(1)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_masters(3'b100);
    tick();
    tick();
    checks++; if (hmaster !== 2'd2) begin errors++; $display("FAIL areset_pre_hmaster got=%0d exp=2", hmaster); end
    #2;
    Hresetn = 1'b0;
    #1;
    checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL areset_hgrant got=%b exp=001", hgrant); end
    checks++; if (Htrans !== 2'b00) begin errors++; $display("FAIL areset_htrans got=%b exp=00", Htrans); end
    checks++; if (hmaster_dp !== 2'd0) begin errors++; $display("FAIL areset_hmaster_dp got=%0d exp=0", hmaster_dp); end
    @(posedge Hclk);
    #1;
    Hresetn = 1'b1;
    // A fresh quantum: M0 should keep the bus for exactly four transfers.
    set_masters(3'b011);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (hmaster !== ((c < 4) ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL areset_quantum c=%0d got=%0d exp=%0d", c, hmaster, (c < 4) ? 0 : 1);
      end
    end
  endtask

`ifdef ARB_HLOCK_EN
  task automatic test_hlock();
    do_reset();
    set_masters(3'b010);
    m_hlock = 3'b010;
    tick();
    set_masters(3'b111);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (hmaster !== 2'd1) begin errors++; $display("FAIL hlock_hold c=%0d got=%0d exp=1", c, hmaster); end
    end
    m_hlock = 3'b000;
    tick();
    checks++; if (hgrant !== 3'b100) begin errors++; $display("FAIL hlock_release got=%b exp=100", hgrant); end
  endtask
`else
  task automatic test_hlock_ignored();
    do_reset();
    m_hlock = 3'b111;
    set_masters(3'b111);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (hmaster !== ((c < 4) ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL hlock_ignored c=%0d got=%0d exp=%0d", c, hmaster, (c < 4) ? 0 : 1);
      end
    end
  endtask
`endif

  initial begin
    Hresetn   = 1'b0;
    Hreadyout = 1'b1;
    m_hlock   = '0;
    set_masters('0);
    test_reset();
    test_single_write();
    test_round_robin();
    test_stall();
    test_async_reset();
`ifdef ARB_HLOCK_EN
    test_hlock();
`else
    test_hlock_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
